trap_ctrl: RTL and testbench
============================

# trap_ctrl

Trap-entry and MRET sequencer sitting directly upstream of the CSR file's single write port. On an exception it freezes the pipeline and issues back-to-back CSR writes for mepc, mcause, mtval and mstatus through that port. It then redirects fetch to mtvec and flushes. On MRET it pulses `is_mret` to the CSR file and redirects to mepc. In idle it passes the pipeline's own CSR writes (csrrw/csrrs/csrrc at writeback) straight through.

## Interface
- No parameters. mepc/mcause/mtval/mstatus addresses come from the shared package.
- `clk`  in  1  clock
- `rst_n`  in  1  reset; asynchronous, active-low
- `exc_req`  in  1  exception request from writeback; only sampled in IDLE
- `exc_cause`  in  4  exception code; mcause written as {28'b0, exc_cause}
- `exc_pc`  in  32  PC of faulting instruction
- `exc_tval`  in  32  trap value (bad address or instruction)
- `mret_req`  in  1  MRET at writeback; only sampled in IDLE
- `mepc_in`  in  32  CSR file read data; decode steers the read address to mepc while MRET is in flight
- `mtvec_in`  in  32  CSR file mtvec output
- `mstatus_in`  in  32  current mstatus value
- `pipe_csr_wr_addr`  in  12  pipeline CSR write address
- `pipe_csr_data`  in  32  pipeline CSR write data
- `pipe_wr_csr_n`  in  1  pipeline CSR write enable, active-low
- `csr_wr_addr`  out  12  to CSR file
- `csr_data_in`  out  32  to CSR file
- `wr_csr_n`  out  1  to CSR file, active-low
- `is_mret`  out  1  to CSR file; restores mstatus at the clock edge
- `stall`  out  1  freeze all pipeline registers
- `flush`  out  1  squash IF/ID/EX/MEM contents
- `redirect`  out  1  load `redirect_pc` into the PC register
- `redirect_pc`  out  32  redirect target

## Operation
- States: IDLE, W_MEPC, W_MCAUSE, W_MTVAL, W_MSTATUS, TRAP_RET, MRET_RET.
- IDLE: the `pipe_*` inputs pass through to the `csr_*` outputs. `stall`, `flush`, `redirect` and `is_mret` are 0.
- IDLE priority: `exc_req` > `mret_req` > pipeline write.
  - If `exc_req`=1, the pipeline write in that cycle is suppressed (`wr_csr_n`=1) so the faulting instruction does not commit.
  - If `mret_req` wins, the pipeline write in that cycle is also suppressed.
- IDLE & `exc_req` at an edge:
  - capture `exc_pc`, `exc_cause`, `exc_tval`; next state W_MEPC.
- Write states drive `wr_csr_n`=0 with the address and data below. Each write commits at the edge that leaves the state.
  - W_MEPC: data = captured pc & ~3.
  - W_MCAUSE: data = {28'b0, cause}.
  - W_MTVAL: data = captured tval.
  - W_MSTATUS: MPP[12:11]=2'b11, MPIE[7]=`mstatus_in`[3], MIE[3]=0; all other bits taken from `mstatus_in`.
- TRAP_RET: `redirect`=1, `redirect_pc`=`mtvec_in` & ~3 (direct mode only), `flush`=1, `wr_csr_n`=1. Next state IDLE.
- IDLE & `mret_req` (no `exc_req`) at an edge: capture `mepc_in`; next state MRET_RET.
- MRET_RET: `is_mret`=1, `redirect`=1, `redirect_pc`=captured mepc, `flush`=1. Next state IDLE.
- `stall` = (state != IDLE) && (state != TRAP_RET) && (state != MRET_RET).
- `exc_req`, `mret_req` and `pipe_*` are ignored outside IDLE; pipeline writes there are dropped.

## Timing
- Trap: request edge E0, mepc write E1, mcause E2, mtval E3, mstatus E4. Redirect is visible in cycle 5 and the PC loads at E5.
- MRET: capture at E0; `is_mret`/redirect asserted in cycle 1; PC and mstatus update at E1.
- Reset (async, any state): state=IDLE, captured registers=0, `stall`=`flush`=`redirect`=`is_mret`=0, `redirect_pc`=0, `csr_*` outputs follow `pipe_*`.
- Reset mid-sequence: abort immediately; the CSR file resets on the same `rst_n`, so no partial-trap state survives.
- Back-to-back: `exc_req` held high in the cycle after TRAP_RET starts a new trap (IDLE is re-entered at E5).

## Configuration
- `TRAP_MTVAL_EN` defined: W_MTVAL present as above; trap entry takes 5 cycles.
- Not defined: W_MTVAL removed, W_MCAUSE goes directly to W_MSTATUS, mtval is left untouched, `exc_tval` is unused. Trap entry takes 4 cycles; all other timing shifts one cycle earlier.

## Structure
- Shared package `csr_pkg`: CSR address constants (0x300, 0x305, 0x341, 0x342, 0x343), mstatus bit positions (MIE=3, MPIE=7, MPP=12:11), exception code constants, FSM state encoding.
- One sub-module, `trap_seq_fsm`: state register, capture registers, next-state logic.
- Top level: write-port mux and output decode.

## Test plan
- IDLE pass-through: `pipe_wr_csr_n`=0, addr 0x340, data 0xDEADBEEF -> identical `csr_*` outputs the same cycle; `stall`=0.
- Illegal instruction: cause=2, pc=0x0001_0104, tval=0x0000_FFFF, mstatus=0x0000_0008, mtvec=0x0001_0201 -> writes 0x341=0x0001_0104, 0x342=0x2, 0x343=0xFFFF, 0x300=0x0000_1880; then redirect to 0x0001_0200 with flush.
- MRET: `mepc_in`=0x0001_0108 -> next cycle `is_mret`=1, `redirect_pc`=0x0001_0108, `flush`=1; no stall cycle.
- Simultaneous `exc_req`, `mret_req` and pipeline write -> trap sequence runs; pipeline write is never issued; `is_mret` stays 0.
- `rst_n` low during W_MCAUSE -> all outputs return to reset values asynchronously; FSM in IDLE after release.
- Without `TRAP_MTVAL_EN`: same trap as the illegal-instruction case -> no write to 0x343; redirect occurs one cycle earlier.

Source files
------------

// File: rtl/csr_pkg.sv
// Shared CSR definitions: machine-mode CSR addresses, mstatus bit positions,
// exception codes and the trap sequencer state encoding.
package csr_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    localparam logic [3:0] EXC_INSTR_MISALIGN = 4'd0;
    localparam logic [3:0] EXC_INSTR_FAULT    = 4'd1;
    localparam logic [3:0] EXC_ILLEGAL_INSTR  = 4'd2;
    localparam logic [3:0] EXC_BREAKPOINT     = 4'd3;
    localparam logic [3:0] EXC_LOAD_MISALIGN  = 4'd4;
    localparam logic [3:0] EXC_LOAD_FAULT     = 4'd5;
    localparam logic [3:0] EXC_STORE_MISALIGN = 4'd6;
    localparam logic [3:0] EXC_STORE_FAULT    = 4'd7;
    localparam logic [3:0] EXC_ECALL_M        = 4'd11;

    typedef enum logic [2:0] {
        IDLE,
        W_MEPC,
        W_MCAUSE,
        W_MTVAL,
        W_MSTATUS,
        TRAP_RET,
        MRET_RET
    } trap_state_t;

    // Trap entry: MPP <- M, MPIE <- MIE, MIE <- 0, everything else preserved.
    function automatic logic [31:0] mstatus_on_trap(input logic [31:0] cur);
        logic [31:0] res;
        res = cur;
        res[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        res[MSTATUS_MPIE]                  = cur[MSTATUS_MIE];
        res[MSTATUS_MIE]                   = 1'b0;
        return res;
    endfunction

endpackage

// File: rtl/trap_ctrl_if.sv
// Connection between the trap controller and the CSR file: the single write
// port plus the mret strobe, and the CSR values the controller reads back.
interface trap_ctrl_if;
    logic [11:0] csr_wr_addr;
    logic [31:0] csr_data_in;
    logic        wr_csr_n;
    logic        is_mret;
    logic [31:0] mepc_in;
    logic [31:0] mtvec_in;
    logic [31:0] mstatus_in;

    modport master (
        output csr_wr_addr, csr_data_in, wr_csr_n, is_mret,
        input  mepc_in, mtvec_in, mstatus_in
    );

    modport slave (
        input  csr_wr_addr, csr_data_in, wr_csr_n, is_mret,
        output mepc_in, mtvec_in, mstatus_in
    );
endinterface

// File: rtl/trap_seq_fsm.sv
// Trap/MRET sequencer state machine with its capture registers.
// TRAP_MTVAL_EN: when defined, the sequence includes the W_MTVAL write state.
module trap_seq_fsm
    import csr_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        exc_req,
    input  logic        mret_req,
    input  logic [3:0]  exc_cause,
    input  logic [31:0] exc_pc,
    input  logic [31:0] exc_tval,
    input  logic [31:0] mepc_in,
    output trap_state_t state,
    output logic [3:0]  cap_cause,
    output logic [31:0] cap_pc,
    output logic [31:0] cap_tval,
    output logic [31:0] cap_mepc
);

    trap_state_t state_reg, state_next;
    logic [3:0]  cause_reg, cause_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] mepc_reg, mepc_next;

`ifdef TRAP_MTVAL_EN
    logic [31:0] tval_reg, tval_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tval_reg <= '0;
        else        tval_reg <= tval_next;
    end

    always_comb begin
        tval_next = tval_reg;
        if (state_reg == IDLE && exc_req) tval_next = exc_tval;
    end

    assign cap_tval = tval_reg;
`else
    logic unused_tval;
    assign unused_tval = ^exc_tval;
    assign cap_tval    = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cause_reg <= '0;
            pc_reg    <= '0;
            mepc_reg  <= '0;
        end else begin
            state_reg <= state_next;
            cause_reg <= cause_next;
            pc_reg    <= pc_next;
            mepc_reg  <= mepc_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cause_next = cause_reg;
        pc_next    = pc_reg;
        mepc_next  = mepc_reg;
        case (state_reg)
            IDLE: begin
                // Exceptions win over MRET; requests are only looked at here.
                if (exc_req) begin
                    state_next = W_MEPC;
                    cause_next = exc_cause;
                    pc_next    = exc_pc;
                end else if (mret_req) begin
                    state_next = MRET_RET;
                    mepc_next  = mepc_in;
                end
            end
            W_MEPC: state_next = W_MCAUSE;
`ifdef TRAP_MTVAL_EN
            W_MCAUSE: state_next = W_MTVAL;
`else
            W_MCAUSE: state_next = W_MSTATUS;
`endif
            W_MTVAL:   state_next = W_MSTATUS;
            W_MSTATUS: state_next = TRAP_RET;
            TRAP_RET:  state_next = IDLE;
            MRET_RET:  state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    assign state     = state_reg;
    assign cap_cause = cause_reg;
    assign cap_pc    = pc_reg;
    assign cap_mepc  = mepc_reg;

endmodule

// File: rtl/trap_ctrl.sv
// Trap-entry / MRET sequencer in front of the CSR file write port: muxes trap
// writes over pipeline writes and decodes stall/flush/redirect. Macro: TRAP_MTVAL_EN.
module trap_ctrl
    import csr_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               exc_req,
    input  logic [3:0]         exc_cause,
    input  logic [31:0]        exc_pc,
    input  logic [31:0]        exc_tval,
    input  logic               mret_req,
    input  logic [11:0]        pipe_csr_wr_addr,
    input  logic [31:0]        pipe_csr_data,
    input  logic               pipe_wr_csr_n,
    trap_ctrl_if.master        csr,
    output logic               stall,
    output logic               flush,
    output logic               redirect,
    output logic [31:0]        redirect_pc
);

    trap_state_t state;
    logic [3:0]  cap_cause;
    logic [31:0] cap_pc;
    logic [31:0] cap_tval;
    logic [31:0] cap_mepc;

    trap_seq_fsm u_fsm (
        .clk       (clk),
        .rst_n     (rst_n),
        .exc_req   (exc_req),
        .mret_req  (mret_req),
        .exc_cause (exc_cause),
        .exc_pc    (exc_pc),
        .exc_tval  (exc_tval),
        .mepc_in   (csr.mepc_in),
        .state     (state),
        .cap_cause (cap_cause),
        .cap_pc    (cap_pc),
        .cap_tval  (cap_tval),
        .cap_mepc  (cap_mepc)
    );

    always_comb begin
        csr.csr_wr_addr = pipe_csr_wr_addr;
        csr.csr_data_in = pipe_csr_data;
        csr.wr_csr_n    = 1'b1;
        csr.is_mret     = 1'b0;
        stall           = 1'b0;
        flush           = 1'b0;
        redirect        = 1'b0;
        redirect_pc     = '0;
        case (state)
            // A faulting or returning instruction must not commit its own write.
            IDLE: csr.wr_csr_n = pipe_wr_csr_n | exc_req | mret_req;
            W_MEPC: begin
                csr.wr_csr_n    = 1'b0;
                csr.csr_wr_addr = CSR_MEPC;
                csr.csr_data_in = cap_pc & ~32'd3;
                stall           = 1'b1;
            end
            W_MCAUSE: begin
                csr.wr_csr_n    = 1'b0;
                csr.csr_wr_addr = CSR_MCAUSE;
                csr.csr_data_in = {28'b0, cap_cause};
                stall           = 1'b1;
            end
            W_MTVAL: begin
                csr.wr_csr_n    = 1'b0;
                csr.csr_wr_addr = CSR_MTVAL;
                csr.csr_data_in = cap_tval;
                stall           = 1'b1;
            end
            W_MSTATUS: begin
                csr.wr_csr_n    = 1'b0;
                csr.csr_wr_addr = CSR_MSTATUS;
                csr.csr_data_in = mstatus_on_trap(csr.mstatus_in);
                stall           = 1'b1;
            end
            TRAP_RET: begin
                redirect    = 1'b1;
                flush       = 1'b1;
                redirect_pc = csr.mtvec_in & ~32'd3;
            end
            MRET_RET: begin
                csr.is_mret = 1'b1;
                redirect    = 1'b1;
                flush       = 1'b1;
                redirect_pc = cap_mepc;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// Randomized scoreboard bench for trap_ctrl: stimulus pushes expected CSR
// writes / redirects, a negedge monitor pops and compares them.
module tb_trap_ctrl;

`ifdef TRAP_MTVAL_EN
    localparam int TRAP_LEN = 5;
`else
    localparam int TRAP_LEN = 4;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        exc_req = 1'b0;
    logic [3:0]  exc_cause = '0;
    logic [31:0] exc_pc = '0;
    logic [31:0] exc_tval = '0;
    logic        mret_req = 1'b0;
    logic [11:0] pipe_csr_wr_addr = '0;
    logic [31:0] pipe_csr_data = '0;
    logic        pipe_wr_csr_n = 1'b1;
    logic        stall, flush, redirect;
    logic [31:0] redirect_pc;

    trap_ctrl_if csr_bus ();

    trap_ctrl dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .exc_req          (exc_req),
        .exc_cause        (exc_cause),
        .exc_pc           (exc_pc),
        .exc_tval         (exc_tval),
        .mret_req         (mret_req),
        .pipe_csr_wr_addr (pipe_csr_wr_addr),
        .pipe_csr_data    (pipe_csr_data),
        .pipe_wr_csr_n    (pipe_wr_csr_n),
        .csr              (csr_bus),
        .stall            (stall),
        .flush            (flush),
        .redirect         (redirect),
        .redirect_pc      (redirect_pc)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected output word: {wr_n, redirect, is_mret, flush, stall, addr, data/redirect_pc}
    typedef struct {
        string       name;
        logic [48:0] word;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   chk_cnt = 0;
    int   pass_cnt = 0;
    bit   mon_en = 1'b0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endfunction

    function automatic void push(input string name, input logic [48:0] word, input int c);
        exp_t e;
        e.name = name;
        e.word = word;
        e.cyc  = c;
        q.push_back(e);
    endfunction

    // Monitor: anything the DUT presents must match the head of the queue.
    exp_t        mon_e;
    logic [48:0] mon_act;
    always @(negedge clk) begin
        if (mon_en) begin
            if (redirect)
                mon_act = {csr_bus.wr_csr_n, redirect, csr_bus.is_mret, flush, stall, 12'h000, redirect_pc};
            else
                mon_act = {csr_bus.wr_csr_n, redirect, csr_bus.is_mret, flush, stall,
                           csr_bus.csr_wr_addr, csr_bus.csr_data_in};
            if (!csr_bus.wr_csr_n || redirect || csr_bus.is_mret || flush || stall) begin
                if (q.size() == 0) begin
                    check("unexpected_output", {15'h0, mon_act}, 64'h0);
                end else begin
                    mon_e = q.pop_front();
                    check(mon_e.name, {15'h0, mon_act}, {15'h0, mon_e.word});
                    check({mon_e.name, "_cycle"}, 64'(cyc), 64'(mon_e.cyc));
                    $display("txn %s cyc=%0d out=%h", mon_e.name, cyc, mon_act);
                end
            end else if (q.size() > 0 && q[0].cyc <= cyc) begin
                mon_e = q.pop_front();
                check({mon_e.name, "_missing"}, 64'(cyc), 64'(mon_e.cyc) - 64'd1000);
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        exc_req       = 1'b0;
        mret_req      = 1'b0;
        pipe_wr_csr_n = 1'b1;
    endtask

    // Busy-cycle noise: requests and pipeline writes here must all be ignored.
    task automatic garbage();
        exc_req          = 1'($urandom);
        mret_req         = 1'($urandom);
        pipe_wr_csr_n    = 1'($urandom);
        pipe_csr_wr_addr = 12'($urandom);
        pipe_csr_data    = $urandom;
        exc_pc           = $urandom;
        exc_cause        = 4'($urandom);
        exc_tval         = $urandom;
        csr_bus.mepc_in  = $urandom;
    endtask

    function automatic logic [31:0] model_mstatus(input logic [31:0] m);
        return (m & 32'hFFFF_E777) | 32'h0000_1800 | (m[3] ? 32'h0000_0080 : 32'h0);
    endfunction

    task automatic do_pipe(input logic [11:0] addr, input logic [31:0] data);
        pipe_csr_wr_addr = addr;
        pipe_csr_data    = data;
        pipe_wr_csr_n    = 1'b0;
        push("pipe_wr", {5'b00000, addr, data}, cyc);
        next_cycle();
        quiet();
    endtask

    task automatic do_trap(input logic [3:0] cause, input logic [31:0] pc, input logic [31:0] tval,
                           input logic [31:0] mst, input logic [31:0] mtv,
                           input bit also_mret, input bit also_pipe);
        int c;
        c                  = cyc;
        exc_req            = 1'b1;
        exc_cause          = cause;
        exc_pc             = pc;
        exc_tval           = tval;
        mret_req           = also_mret;
        pipe_wr_csr_n      = !also_pipe;
        pipe_csr_wr_addr   = 12'h340;
        pipe_csr_data      = $urandom;
        csr_bus.mstatus_in = mst;
        csr_bus.mtvec_in   = mtv;
        push("mepc", {5'b00001, 12'h341, pc & 32'hFFFF_FFFC}, c + 1);
        push("mcause", {5'b00001, 12'h342, 28'h0, cause}, c + 2);
`ifdef TRAP_MTVAL_EN
        push("mtval", {5'b00001, 12'h343, tval}, c + 3);
`endif
        push("mstatus", {5'b00001, 12'h300, model_mstatus(mst)}, c + TRAP_LEN - 1);
        push("trap_redirect", {5'b11010, 12'h000, mtv & 32'hFFFF_FFFC}, c + TRAP_LEN);
        for (int i = 0; i < TRAP_LEN; i++) begin
            next_cycle();
            garbage();
        end
        next_cycle();
        quiet();
    endtask

    task automatic do_mret(input logic [31:0] mepc, input bit also_pipe);
        csr_bus.mepc_in  = mepc;
        mret_req         = 1'b1;
        exc_req          = 1'b0;
        pipe_wr_csr_n    = !also_pipe;
        pipe_csr_wr_addr = 12'h341;
        pipe_csr_data    = $urandom;
        push("mret_redirect", {5'b11110, 12'h000, mepc}, cyc + 1);
        next_cycle();
        garbage();
        next_cycle();
        quiet();
    endtask

    initial begin
        csr_bus.mepc_in    = '0;
        csr_bus.mtvec_in   = '0;
        csr_bus.mstatus_in = '0;

        // Reset: outputs idle, CSR port follows the pipeline.
        pipe_wr_csr_n    = 1'b0;
        pipe_csr_wr_addr = 12'h340;
        pipe_csr_data    = 32'h1234_5678;
        repeat (2) @(posedge clk);
        #2;
        check("rst_ctl", {60'h0, stall, flush, redirect, csr_bus.is_mret}, 64'h0);
        check("rst_redirect_pc", 64'(redirect_pc), 64'h0);
        check("rst_passthru", {19'h0, csr_bus.wr_csr_n, csr_bus.csr_wr_addr, csr_bus.csr_data_in},
              {19'h0, 1'b0, 12'h340, 32'h1234_5678});
        quiet();
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
        mon_en = 1'b1;

        // Directed cases
        do_pipe(12'h340, 32'hDEAD_BEEF);
        do_trap(4'd2, 32'h0001_0104, 32'h0000_FFFF, 32'h0000_0008, 32'h0001_0201, 1'b0, 1'b0);
        do_mret(32'h0001_0108, 1'b0);
        do_trap(4'd11, 32'h0000_2003, 32'h0BAD_0BAD, 32'h0000_0000, 32'h0000_4000, 1'b1, 1'b1);
        do_trap(4'd5, 32'h8000_0010, 32'h0000_1234, 32'hFFFF_FFFF, 32'h0000_8003, 1'b0, 1'b0);
        do_mret(32'h0000_3000, 1'b1);

        // Randomized mix, occasionally back-to-back
        for (int n = 0; n < 120; n++) begin
            case ($urandom_range(0, 2))
                0: do_pipe(12'($urandom), $urandom);
                1: do_trap(4'($urandom), $urandom, $urandom, $urandom, $urandom,
                           1'($urandom), 1'($urandom));
                default: do_mret($urandom, 1'($urandom));
            endcase
            repeat ($urandom_range(0, 2)) next_cycle();
        end

        // Reset in the middle of a trap (W_MCAUSE)
        do_pipe(12'h305, 32'h0000_0100);
        exc_req            = 1'b1;
        exc_cause          = 4'd2;
        exc_pc             = 32'h0001_0104;
        exc_tval           = 32'h0;
        csr_bus.mstatus_in = 32'h8;
        csr_bus.mtvec_in   = 32'h100;
        push("mepc", {5'b00001, 12'h341, 32'h0001_0104}, cyc + 1);
        next_cycle();
        quiet();
        next_cycle();
        mon_en = 1'b0;
        check("midrst_stall_before", 64'(stall), 64'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_ctl", {60'h0, stall, flush, redirect, csr_bus.is_mret}, 64'h0);
        check("midrst_redirect_pc", 64'(redirect_pc), 64'h0);
        check("midrst_wr_n", 64'(csr_bus.wr_csr_n), 64'h1);
        q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
        mon_en = 1'b1;
        do_pipe(12'h340, 32'hCAFE_F00D);
        do_mret(32'h0000_0200, 1'b0);
        do_trap(4'd2, 32'h0001_0104, 32'h0000_FFFF, 32'h0000_0008, 32'h0001_0201, 1'b0, 1'b0);

        repeat (3) next_cycle();
        check("queue_drained", 64'(q.size()), 64'h0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    // Hard bound on total runtime.
    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, %0d/%0d checks passed", pass_cnt, chk_cnt);
        $fatal(1, "timeout");
    end

endmodule
